// File: rtl/seg7_reader.sv
// Settling decoder for an active-low 7-segment bus: waits for a pattern to hold
// still, decodes it to a hex digit (or blank/error) and hands it out over valid/ready.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic [0:6] SEG,
   input  logic       READY,
   output logic       VALID,
   output logic [3:0] DIGIT,
   output logic       BLANK,
   output logic       ERR,
   output logic       OVERRUN,
   output logic [7:0] ERR_CNT,
   output logic       dbg_state
);

   localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [0:6] SEG_OFF  = 7'b1111111;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [0:6] s_q, acc_q;
   logic [7:0] cnt;
   logic       accept, load, drop;
   logic [3:0] dec_digit;
   logic       dec_blank, dec_err;

   // An accept fires on the single edge where the stability count reaches its limit.
   assign accept = (SEG == s_q) && (cnt == CNT_LAST) && (s_q != acc_q);

   always_comb begin
      dec_digit = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (s_q)
         7'b0000001: dec_digit = 4'h0;
         7'b1001111: dec_digit = 4'h1;
         7'b0010010: dec_digit = 4'h2;
         7'b0000110: dec_digit = 4'h3;
         7'b1001100: dec_digit = 4'h4;
         7'b0100100: dec_digit = 4'h5;
         7'b0100000: dec_digit = 4'h6;
         7'b0001111: dec_digit = 4'h7;
         7'b0000000: dec_digit = 4'h8;
         7'b0000100: dec_digit = 4'h9;
         7'b0001000: dec_digit = 4'hA;
         7'b1100000: dec_digit = 4'hB;
         7'b0110001: dec_digit = 4'hC;
         7'b1000010: dec_digit = 4'hD;
         7'b0110000: dec_digit = 4'hE;
         7'b0111000: dec_digit = 4'hF;
         7'b1111111: dec_blank = 1'b1;
         default:    dec_err   = 1'b1;
      endcase
   end

   // Handshake: VALID holds DIGIT/BLANK/ERR steady until the edge where VALID && READY;
   // READY is ignored while VALID is low. An accept that finds the slot still
   // occupied and not being taken is dropped and flagged on OVERRUN.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               load    = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            if (accept) begin
               if (READY) load = 1'b1;
               else       drop = 1'b1;
            end else if (READY) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         state_q <= EMPTY;
         s_q     <= SEG_OFF;
         acc_q   <= SEG_OFF;
         cnt     <= 8'd0;
         DIGIT   <= 4'h0;
         BLANK   <= 1'b0;
         ERR     <= 1'b0;
         OVERRUN <= 1'b0;
         ERR_CNT <= 8'd0;
      end else begin
         state_q <= state_d;
         if (SEG != s_q) begin
            s_q <= SEG;
            cnt <= 8'd0;
         end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 8'd1;
         end
         if (accept) begin
            acc_q <= s_q;
            if (dec_err && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
         end
         if (load) begin
            DIGIT <= dec_digit;
            BLANK <= dec_blank;
            ERR   <= dec_err;
         end
         if (drop) OVERRUN <= 1'b1;
      end
   end

   assign VALID     = (state_q == FULL);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: latency, glitch rejection, overrun, error
// saturation and reset behaviour, with a second instance at STABLE_CYCLES=1.
module tb_seg7_reader;

   logic       CLOCK_50 = 1'b0;
   logic       RST_N;
   logic [0:6] SEG, seg1;
   logic       READY, ready1;
   logic       VALID, BLANK, ERR, OVERRUN, dbg_state;
   logic [3:0] DIGIT;
   logic [7:0] ERR_CNT;
   logic       valid1, blank1, err1, overrun1, dbg1;
   logic [3:0] digit1;
   logic [7:0] err_cnt1;

   int total = 0;
   int bad   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   seg7_reader #(.STABLE_CYCLES(4)) dut (
      .CLOCK_50(CLOCK_50), .RST_N(RST_N), .SEG(SEG), .READY(READY),
      .VALID(VALID), .DIGIT(DIGIT), .BLANK(BLANK), .ERR(ERR),
      .OVERRUN(OVERRUN), .ERR_CNT(ERR_CNT), .dbg_state(dbg_state)
   );

   seg7_reader #(.STABLE_CYCLES(1)) dut1 (
      .CLOCK_50(CLOCK_50), .RST_N(RST_N), .SEG(seg1), .READY(ready1),
      .VALID(valid1), .DIGIT(digit1), .BLANK(blank1), .ERR(err1),
      .OVERRUN(overrun1), .ERR_CNT(err_cnt1), .dbg_state(dbg1)
   );

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   logic [7:0] exp_cnt;

   initial begin
      // reset hold with a blank bus
      RST_N = 1'b0; SEG = 7'b1111111; READY = 1'b1;
      seg1 = 7'b1111111; ready1 = 1'b1;
      step(20);
      chk1("rst_valid", VALID, 1'b0);
      chk8("rst_errcnt", ERR_CNT, 8'd0);
      chk1("rst_overrun", OVERRUN, 1'b0);
      chk4("rst_digit", DIGIT, 4'h0);
      chk1("rst_dbg_state", dbg_state, 1'b0);
      RST_N = 1'b1;
      step(10);
      chk1("blank_after_reset_no_event", VALID, 1'b0);

      // STABLE_CYCLES=1 latency: event visible after edge t+1
      seg1 = 7'b0010010;
      step(1);
      chk1("s1_valid_t", valid1, 1'b0);
      step(1);
      chk1("s1_valid_t1", valid1, 1'b1);
      chk4("s1_digit", digit1, 4'h2);
      step(1);
      chk1("s1_cleared", valid1, 1'b0);

      // STABLE_CYCLES=4 latency: event visible after edge t+4, then taken
      SEG = 7'b0010010;
      step(4);
      chk1("lat_valid_t3", VALID, 1'b0);
      step(1);
      chk1("lat_valid_t4", VALID, 1'b1);
      chk4("lat_digit", DIGIT, 4'h2);
      chk1("lat_blank", BLANK, 1'b0);
      chk1("lat_err", ERR, 1'b0);
      chk1("lat_dbg_full", dbg_state, 1'b1);
      step(1);
      chk1("lat_cleared", VALID, 1'b0);

      // glitch rejection
      SEG = 7'b0000110;
      step(5);
      chk1("g3_valid", VALID, 1'b1);
      chk4("g3_digit", DIGIT, 4'h3);
      step(1);
      SEG = 7'b0000000;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk1("glitch_no_event", VALID, 1'b0);
      end
      SEG = 7'b0000110;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk1("return_no_event", VALID, 1'b0);
      end
      SEG = 7'b0000000;
      step(4);
      chk1("g8_valid_t3", VALID, 1'b0);
      step(1);
      chk1("g8_valid", VALID, 1'b1);
      chk4("g8_digit", DIGIT, 4'h8);
      step(1);
      chk1("g8_cleared", VALID, 1'b0);

      // overrun: second event dropped while the first waits
      READY = 1'b0;
      SEG = 7'b1001111;
      step(5);
      chk1("ov_valid1", VALID, 1'b1);
      chk4("ov_digit1", DIGIT, 4'h1);
      chk1("ov_not_yet", OVERRUN, 1'b0);
      SEG = 7'b0100100;
      step(5);
      chk1("ov_set", OVERRUN, 1'b1);
      chk1("ov_still_valid", VALID, 1'b1);
      chk4("ov_held_digit", DIGIT, 4'h1);
      READY = 1'b1;
      step(1);
      chk1("ov_transfer", VALID, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk1("ov_single_transfer", VALID, 1'b0);
      end

      // transfer and accept on the same edge: new event replaces old
      READY = 1'b0;
      SEG = 7'b0001111;
      step(5);
      chk4("swap_old_digit", DIGIT, 4'h7);
      SEG = 7'b1100000;
      step(4);
      READY = 1'b1;
      step(1);
      chk1("swap_valid", VALID, 1'b1);
      chk4("swap_new_digit", DIGIT, 4'hB);
      step(1);
      chk1("swap_cleared", VALID, 1'b0);
      chk1("ov_sticky", OVERRUN, 1'b1);

      // blank event
      SEG = 7'b1111111;
      step(5);
      chk1("blank_valid", VALID, 1'b1);
      chk1("blank_flag", BLANK, 1'b1);
      chk4("blank_digit", DIGIT, 4'h0);
      chk1("blank_err", ERR, 1'b0);
      step(1);

      // invalid patterns, error count saturation
      exp_cnt = 8'd0;
      for (int i = 0; i < 300; i++) begin
         SEG = (i % 2 == 0) ? 7'b1010101 : 7'b0101010;
         if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
         step(5);
         chk1("inv_valid", VALID, 1'b1);
         chk1("inv_err", ERR, 1'b1);
         chk4("inv_digit", DIGIT, 4'h0);
         chk8("inv_errcnt", ERR_CNT, exp_cnt);
      end
      chk8("inv_saturated", ERR_CNT, 8'd255);
      step(1);

      // reset with an event pending, then re-emit of the same pattern
      SEG = 7'b0000100;
      step(5);
      chk1("pre_rst_valid", VALID, 1'b1);
      chk4("pre_rst_digit", DIGIT, 4'h9);
      RST_N = 1'b0;
      step(1);
      chk1("mid_rst_valid", VALID, 1'b0);
      chk4("mid_rst_digit", DIGIT, 4'h0);
      chk1("mid_rst_err", ERR, 1'b0);
      chk1("mid_rst_blank", BLANK, 1'b0);
      chk1("mid_rst_overrun", OVERRUN, 1'b0);
      chk8("mid_rst_errcnt", ERR_CNT, 8'd0);
      RST_N = 1'b1;
      step(4);
      chk1("reemit_t3", VALID, 1'b0);
      step(1);
      chk1("reemit_valid", VALID, 1'b1);
      chk4("reemit_digit", DIGIT, 4'h9);
      step(1);
      chk1("reemit_cleared", VALID, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
